// File: rtl/psram_pkg.sv
// Shared constants and FSM encoding for the PSRAM read path.
// Imported by the arbiter top and its sub-blocks.
package psram_pkg;

  localparam logic [7:0] PSRAM_RD_CMD     = 8'h03;
  localparam int         PSRAM_XFER_BYTES = 4;
  localparam logic [2:0] PSRAM_SIZE_WORD  = 3'd4;
  localparam int         PSRAM_ADDR_BITS  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr,
// searched in cyclic order. Returns one-hot grant and its index.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[IW'(c)]) begin
        any          = 1'b1;
        gnt[IW'(c)]  = 1'b1;
        idx          = IW'(c);
      end
    end
  end

endmodule

// File: rtl/psram_rd_arbiter.sv
// Round-robin burst read scheduler sharing one PSRAM controller
// port between NUM_REQ loaders; one word per controller transaction.
module psram_rd_arbiter
  import psram_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter int         LEN_BITS  = 16,
  parameter int         ADDR_BITS = PSRAM_ADDR_BITS,
  parameter logic [7:0] RD_CMD    = PSRAM_RD_CMD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*LEN_BITS-1:0]  req_len,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [31:0]                  rdata,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [NUM_REQ-1:0]           burst_done,
  output logic                         busy,
  output logic [ADDR_BITS-1:0]         psram_addr,
  output logic [2:0]                   psram_size,
  output logic                         psram_start,
  output logic [7:0]                   psram_cmd,
  output logic                         psram_rd_wr,
  output logic                         psram_qspi,
  output logic                         psram_qpi,
  output logic                         psram_short_cmd,
  input  logic                         psram_done,
  input  logic [31:0]                  psram_data_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [ADDR_BITS-1:0] STEP =
    ADDR_BITS'(PSRAM_XFER_BYTES);

  rd_state_e            state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [LEN_BITS-1:0]  remaining;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [LEN_BITS-1:0]  sel_len;

  assign psram_size      = PSRAM_SIZE_WORD;
  assign psram_cmd       = RD_CMD;
  assign psram_rd_wr     = 1'b0;
  assign psram_qspi      = 1'b0;
  assign psram_qpi       = 1'b0;
  assign psram_short_cmd = 1'b0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_len  = req_len[i*LEN_BITS +: LEN_BITS];
      end
    end
  end

  function automatic logic [IW-1:0] ptr_after(
    input logic [IW-1:0] k
  );
    return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cur_addr    <= '0;
      remaining   <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      burst_done  <= '0;
      busy        <= 1'b0;
      rdata       <= '0;
      psram_addr  <= '0;
      psram_start <= 1'b0;
    end else begin
      gnt         <= '0;
      rvalid      <= '0;
      burst_done  <= '0;
      psram_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt       <= arb_gnt;
            owner     <= arb_idx;
            cur_addr  <= sel_addr;
            remaining <= sel_len;
            // empty burst completes without touching the PSRAM
            if (sel_len == '0) begin
              burst_done <= arb_gnt;
              rr_ptr     <= ptr_after(arb_idx);
            end else begin
              state <= ST_ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          psram_addr  <= cur_addr;
          psram_start <= 1'b1;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (psram_done) begin
            rdata     <= psram_data_o;
            rvalid    <= ONE << owner;
            cur_addr  <= cur_addr + STEP;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_BITS'(1)) begin
              burst_done <= ONE << owner;
              rr_ptr     <= ptr_after(owner);
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_rd_arbiter.sv
// Directed + randomized bench for psram_rd_arbiter with an
// abstract burst/arbitration model and a latency-randomized PSRAM.
module tb_psram_rd_arbiter;

  localparam int N  = 4;
  localparam int LB = 16;
  localparam int AB = 24;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AB-1:0] req_addr;
  logic [N*LB-1:0] req_len;
  logic [N-1:0]    gnt;
  logic [31:0]     rdata;
  logic [N-1:0]    rvalid;
  logic [N-1:0]    burst_done;
  logic            busy;
  logic [AB-1:0]   psram_addr;
  logic [2:0]      psram_size;
  logic            psram_start;
  logic [7:0]      psram_cmd;
  logic            psram_rd_wr;
  logic            psram_qspi;
  logic            psram_qpi;
  logic            psram_short_cmd;
  logic            psram_done;
  logic [31:0]     psram_data_o;

  psram_rd_arbiter #(
    .NUM_REQ(N), .LEN_BITS(LB), .ADDR_BITS(AB), .RD_CMD(8'h03)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .gnt             (gnt),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .burst_done      (burst_done),
    .busy            (busy),
    .psram_addr      (psram_addr),
    .psram_size      (psram_size),
    .psram_start     (psram_start),
    .psram_cmd       (psram_cmd),
    .psram_rd_wr     (psram_rd_wr),
    .psram_qspi      (psram_qspi),
    .psram_qpi       (psram_qpi),
    .psram_short_cmd (psram_short_cmd),
    .psram_done      (psram_done),
    .psram_data_o    (psram_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            k;
    logic [AB-1:0] a;
    int            len;
  } post_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mptr  = 0;

  int            gq[$];
  int            gcq[$];
  int            rq_idx[$];
  logic [31:0]   rdq[$];
  int            rcq[$];
  int            bdq[$];
  int            bdcq[$];
  logic [AB-1:0] saq[$];
  int            scq[$];
  int            dcq[$];
  post_t         pq[$];
  int            exp_q[$];

  bit            ctl_pend;
  int            ctl_cnt;
  logic [AB-1:0] ctl_addr;

  function automatic logic [31:0] memf(logic [AB-1:0] a);
    return {a[7:0], a} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    gq.delete(); gcq.delete(); rq_idx.delete(); rdq.delete();
    rcq.delete(); bdq.delete(); bdcq.delete(); saq.delete();
    scq.delete(); dcq.delete();
  endtask

  // one cycle: observe outputs at negedge, act as loaders and PSRAM
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (|gnt) begin
      check("gnt_onehot", 64'($onehot(gnt)), 64'(1));
      for (int k = 0; k < N; k++) begin
        if (gnt[k]) begin
          gq.push_back(k);
          gcq.push_back(cyc);
          req[k] = 1'b0;
          req_addr[k*AB +: AB] = AB'($urandom);
          req_len[k*LB +: LB]  = LB'($urandom);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rvalid[k]) begin
        rq_idx.push_back(k);
        rdq.push_back(rdata);
        rcq.push_back(cyc);
      end
      if (burst_done[k]) begin
        bdq.push_back(k);
        bdcq.push_back(cyc);
      end
    end
    psram_done = 1'b0;
    if (psram_start) begin
      saq.push_back(psram_addr);
      scq.push_back(cyc);
      ctl_pend = 1'b1;
      ctl_addr = psram_addr;
      ctl_cnt  = int'($urandom_range(0, 3));
    end
    if (ctl_pend && rst_n) begin
      if (ctl_cnt == 0) begin
        psram_done   = 1'b1;
        psram_data_o = memf(ctl_addr);
        ctl_pend     = 1'b0;
        dcq.push_back(cyc);
      end else begin
        ctl_cnt--;
      end
    end
  endtask

  task automatic post(int k, logic [AB-1:0] a, int len);
    post_t p;
    req[k] = 1'b1;
    req_addr[k*AB +: AB] = a;
    req_len[k*LB +: LB]  = LB'(len);
    p.k = k; p.a = a; p.len = len;
    pq.push_back(p);
  endtask

  // rotating priority: first pending requester at/after pointer
  task automatic model_order(logic [N-1:0] m);
    int p;
    int k;
    p = mptr;
    exp_q.delete();
    while (m != '0) begin
      k = p;
      while (!m[k]) k = (k + 1) % N;
      exp_q.push_back(k);
      m[k] = 1'b0;
      p = (k + 1) % N;
    end
  endtask

  task automatic drain(string tag);
    int            budget;
    int            pi;
    post_t         p;
    logic [AB-1:0] ea;
    logic [AB-1:0] e_sa[$];
    int            e_rv[$];
    logic [31:0]   e_rd[$];
    int            e_bd[$];
    budget = 0;
    do begin
      tick();
      budget++;
    end while ((req != '0 || busy || ctl_pend) && budget < 3000);
    check({tag, ".timeout"}, 64'(budget < 3000), 64'(1));
    check({tag, ".ngnt"}, 64'(gq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gq.size(); i++)
      check({tag, ".order"}, 64'(gq[i]), 64'(exp_q[i]));
    for (int i = 0; i < exp_q.size(); i++) begin
      pi = -1;
      for (int j = 0; j < pq.size(); j++)
        if (pi < 0 && pq[j].k == exp_q[i]) pi = j;
      if (pi >= 0) begin
        p = pq[pi];
        pq.delete(pi);
        if (p.len == 0) e_bd.push_back(p.k);
        for (int w = 0; w < p.len; w++) begin
          ea = p.a + AB'(4 * w);
          e_sa.push_back(ea);
          e_rv.push_back(p.k);
          e_rd.push_back(memf(ea));
          if (w == p.len - 1) e_bd.push_back(p.k);
        end
      end
    end
    check({tag, ".nstart"}, 64'(saq.size()), 64'(e_sa.size()));
    check({tag, ".nrvalid"}, 64'(rq_idx.size()), 64'(e_rv.size()));
    check({tag, ".ndone"}, 64'(bdq.size()), 64'(e_bd.size()));
    for (int i = 0; i < e_sa.size() && i < saq.size(); i++)
      check({tag, ".addr"}, 64'(saq[i]), 64'(e_sa[i]));
    for (int i = 0; i < e_rv.size() && i < rq_idx.size(); i++) begin
      check({tag, ".rv_idx"}, 64'(rq_idx[i]), 64'(e_rv[i]));
      check({tag, ".rdata"}, 64'(rdq[i]), 64'(e_rd[i]));
    end
    for (int i = 0; i < e_bd.size() && i < bdq.size(); i++)
      check({tag, ".done_idx"}, 64'(bdq[i]), 64'(e_bd[i]));
    if (exp_q.size() > 0) mptr = (exp_q[$] + 1) % N;
  endtask

  task automatic chk_reset(string tag);
    check({tag, ".gnt"}, 64'(gnt), 64'(0));
    check({tag, ".rvalid"}, 64'(rvalid), 64'(0));
    check({tag, ".done"}, 64'(burst_done), 64'(0));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".start"}, 64'(psram_start), 64'(0));
    check({tag, ".rdata"}, 64'(rdata), 64'(0));
    check({tag, ".addr"}, 64'(psram_addr), 64'(0));
    check({tag, ".size"}, 64'(psram_size), 64'(4));
    check({tag, ".cmd"}, 64'(psram_cmd), 64'(8'h03));
    check({tag, ".ctl"},
          64'({psram_rd_wr, psram_qspi, psram_qpi, psram_short_cmd}),
          64'(0));
  endtask

  initial begin
    int            p0;
    int            b;
    int            nrv;
    logic [N-1:0]  m;
    logic [AB-1:0] a;
    rst_n        = 1'b0;
    req          = '0;
    req_addr     = '0;
    req_len      = '0;
    psram_done   = 1'b0;
    psram_data_o = '0;
    ctl_pend     = 1'b0;
    ctl_cnt      = 0;
    ctl_addr     = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // contention: all four, one word each, twice
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      for (int k = 0; k < N; k++) post(k, AB'(32'h1000 * (k + 1)), 1);
      model_order(4'hF);
      drain("contention");
      if (gq.size() == 4)
        check("contention.first", 64'(gq[0]), 64'(0));
    end

    // single burst with latency checks
    clear_logs();
    post(0, 24'h000100, 3);
    p0 = cyc;
    model_order(4'b0001);
    drain("single");
    if (saq.size() == 3) begin
      check("single.a0", 64'(saq[0]), 64'(24'h000100));
      check("single.a2", 64'(saq[2]), 64'(24'h000108));
    end
    if (gcq.size() > 0 && scq.size() > 1 && rcq.size() == 3
        && dcq.size() > 0 && bdcq.size() > 0) begin
      check("lat.req_gnt", 64'(gcq[0] - p0), 64'(1));
      check("lat.gnt_start", 64'(scq[0] - gcq[0]), 64'(1));
      check("lat.done_rv", 64'(rcq[0] - dcq[0]), 64'(1));
      check("lat.gap", 64'(scq[1] - rcq[0]), 64'(1));
      check("lat.last", 64'(bdcq[0]), 64'(rcq[2]));
    end

    // fairness: req0 re-raised at once, req2 raised mid-burst
    clear_logs();
    post(0, 24'h002000, 4);
    b = 0;
    while (gq.size() < 1 && b < 20) begin tick(); b++; end
    check("fair.gnt0", 64'(b < 20), 64'(1));
    post(0, 24'h003000, 2);
    tick(); tick();
    post(2, 24'h004000, 1);
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    drain("fair");

    // zero length burst
    clear_logs();
    post(1, 24'h005550, 0);
    model_order(4'b0010);
    drain("zero");
    if (gcq.size() > 0 && bdcq.size() > 0)
      check("zero.same_cycle", 64'(bdcq[0]), 64'(gcq[0]));
    check("zero.no_start", 64'(scq.size()), 64'(0));

    // completion strobe while idle must be ignored
    clear_logs();
    psram_done   = 1'b1;
    psram_data_o = 32'hDEAD_BEEF;
    tick(); tick();
    check("stray_done.rvalid", 64'(rq_idx.size()), 64'(0));
    check("stray_done.busy", 64'(busy), 64'(0));

    // address wrap
    clear_logs();
    post(3, 24'hFFFFFC, 2);
    model_order(4'b1000);
    drain("wrap");
    if (saq.size() == 2)
      check("wrap.a1", 64'(saq[1]), 64'(0));

    // move pointer off zero, then abort a burst with reset
    clear_logs();
    post(1, 24'h006000, 1);
    model_order(4'b0010);
    drain("preabort");
    clear_logs();
    post(2, 24'h007000, 4);
    b = 0;
    while (saq.size() < 2 && b < 60) begin tick(); b++; end
    check("abort.reach", 64'(b < 60), 64'(1));
    nrv = rq_idx.size();
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    psram_done = 1'b0;
    ctl_pend   = 1'b0;
    req        = '0;
    pq.delete();
    tick(); tick();
    check("abort.no_rvalid", 64'(rq_idx.size()), 64'(nrv));
    check("abort.no_done", 64'(bdq.size()), 64'(0));
    rst_n = 1'b1;
    mptr  = 0;
    tick();
    clear_logs();
    post(1, 24'h008000, 2);
    post(3, 24'h009000, 1);
    model_order(4'b1010);
    drain("postreset");

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      clear_logs();
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (m[k]) begin
          a = {AB'($urandom) >> 2, 2'b00};
          if ($urandom_range(0, 3) == 0) a = 24'hFFFFF0;
          post(k, a, int'($urandom_range(0, 5)));
        end
      end
      model_order(m);
      drain("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
